// File: rtl/switch_input.sv
// Debounced push-button block: per-input synchronizer and debounce FSM, sticky
// press/release flags with read-to-clear, a press counter, and a CPU read port.
module switch_input #(
   parameter int unsigned N_IN            = 5,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_IN-1:0] btn,
   input  logic            rd_en,
   input  logic [1:0]      addr,
   output logic [31:0]     rd_data,
   output logic            rd_valid,
   output logic            irq
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {S_LO, W_HI, S_HI, W_LO} db_state_e;

   logic [N_IN-1:0] sync1_q, sync2_q;
   db_state_e       state_q [N_IN];
   db_state_e       state_d [N_IN];
   logic [CW-1:0]   cnt_q   [N_IN];
   logic [CW-1:0]   cnt_d   [N_IN];
   logic [N_IN-1:0] level_c, press_c, release_c;
   logic [N_IN-1:0] press_q, press_d, rel_q, rel_d;
   logic [31:0]     count_q, count_d;
   logic [31:0]     rd_data_q, rd_data_d;
   logic            rd_valid_q, irq_q;
   logic            clr_press_c, clr_rel_c;

   // Debounce FSM per input; counter only runs while waiting on a level change
   always_comb begin
      press_c   = '0;
      release_c = '0;
      level_c   = '0;
      for (int i = 0; i < N_IN; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = '0;
         level_c[i] = (state_q[i] == S_HI) || (state_q[i] == W_LO);
         case (state_q[i])
            S_LO: begin
               if (sync2_q[i]) begin
                  state_d[i] = W_HI;
                  cnt_d[i]   = CW'(1);
               end
            end
            W_HI: begin
               if (!sync2_q[i]) begin
                  state_d[i] = S_LO;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = S_HI;
                  press_c[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
               end
            end
            S_HI: begin
               if (!sync2_q[i]) begin
                  state_d[i] = W_LO;
                  cnt_d[i]   = CW'(1);
               end
            end
            W_LO: begin
               if (sync2_q[i]) begin
                  state_d[i] = S_HI;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i]   = S_LO;
                  release_c[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
               end
            end
            default: state_d[i] = S_LO;
         endcase
      end
   end

   // Register file: flags clear on read but a same-cycle event still lands
   always_comb begin
      clr_press_c = rd_en && (addr == 2'd1);
      clr_rel_c   = rd_en && (addr == 2'd2);
      press_d     = (clr_press_c ? '0 : press_q) | press_c;
      rel_d       = (clr_rel_c ? '0 : rel_q) | release_c;
      count_d     = count_q;
      for (int i = 0; i < N_IN; i++) begin
         count_d = count_d + 32'(press_c[i]);
      end
      rd_data_d = rd_data_q;
      if (rd_en) begin
         case (addr)
            2'd0:    rd_data_d = 32'(level_c);
            2'd1:    rd_data_d = 32'(press_q);
            2'd2:    rd_data_d = 32'(rel_q);
            default: rd_data_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         for (int i = 0; i < N_IN; i++) begin
            state_q[i] <= S_LO;
            cnt_q[i]   <= '0;
         end
         press_q    <= '0;
         rel_q      <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         sync1_q    <= btn;
         sync2_q    <= sync1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         press_q    <= press_d;
         rel_q      <= rel_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_en;
         irq_q      <= |press_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_switch_input.sv
// Self-checking bench for switch_input: reads are scoreboarded through a queue
// of expected values, popped when rd_valid is sampled.
module tb_switch_input;

   localparam int unsigned N_IN = 5;
   localparam int unsigned DB   = 4;

   logic            clk   = 1'b0;
   logic            reset = 1'b0;
   logic [N_IN-1:0] btn   = '0;
   logic            rd_en = 1'b0;
   logic [1:0]      addr  = 2'd0;
   logic [31:0]     rd_data;
   logic            rd_valid;
   logic            irq;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q [$];

   switch_input #(.N_IN(N_IN), .DEBOUNCE_CYCLES(DB)) dut (
      .clk      (clk),
      .reset    (reset),
      .btn      (btn),
      .rd_en    (rd_en),
      .addr     (addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Issue one read from a negedge; returns at the next negedge with the result visible
   task automatic drive_read(input logic [1:0] a, input logic [31:0] e);
      exp_q.push_back(e);
      addr  = a;
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      btn   = '0;
      rd_en = 1'b0;
      exp_q.delete();
      wait_neg(2);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [1:0]  ad [4];
      logic [31:0] e;
      ad = '{2'd0, 2'd1, 2'd2, 2'd3};
      wait_neg(2);
      checks++;
      if (rd_valid !== 1'b0 || irq !== 1'b0 || rd_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs got valid=%b irq=%b data=%h exp 0 0 0", rd_valid, irq, rd_data);
      end
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         drive_read(ad[i], 32'd0);
         e = exp_q.pop_front();
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("FAIL reset_read%0d got valid=%b data=%h exp %h", i, rd_valid, rd_data, e);
         end
      end
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_valid_drop got %b exp 0", rd_valid);
      end
   endtask

   task automatic test_single_press();
      logic [1:0]  ad [2];
      logic [31:0] ex [2];
      logic [31:0] e;
      ad = '{2'd0, 2'd3};
      ex = '{32'h1, 32'd1};
      apply_reset();
      btn[0] = 1'b1;
      wait_neg(5);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL press_irq_early got %b exp 0", irq);
      end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL press_irq_set got %b exp 1", irq);
      end
      for (int i = 0; i < 2; i++) begin
         drive_read(ad[i], ex[i]);
         e = exp_q.pop_front();
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("FAIL single_press_read%0d got valid=%b data=%h exp %h", i, rd_valid, rd_data, e);
         end
      end
   endtask

   // Continues from test_single_press: PRESS=0x1 with btn[0] held
   task automatic test_clear_race();
      logic [1:0]  ad [5];
      logic [31:0] ex [5];
      logic [31:0] e;
      ad = '{2'd0, 2'd3, 2'd2, 2'd2, 2'd3};
      ex = '{32'h0, 32'd2, 32'h3, 32'h0, 32'd2};
      btn[1] = 1'b1;
      wait_neg(5);
      drive_read(2'd1, 32'h1);
      e = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
         errors++;
         $display("FAIL race_old_flags got valid=%b data=%h exp %h", rd_valid, rd_data, e);
      end
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL race_irq_kept got %b exp 1", irq);
      end
      drive_read(2'd1, 32'h2);
      e = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
         errors++;
         $display("FAIL race_new_flag got valid=%b data=%h exp %h", rd_valid, rd_data, e);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL race_irq_drop got %b exp 0", irq);
      end
      btn = '0;
      wait_neg(7);
      for (int i = 0; i < 5; i++) begin
         drive_read(ad[i], ex[i]);
         e = exp_q.pop_front();
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("FAIL race_after_read%0d got valid=%b data=%h exp %h", i, rd_valid, rd_data, e);
         end
      end
   endtask

   // 3-cycle glitch is rejected; exactly DB cycles is accepted
   task automatic test_glitch();
      logic [1:0]  ad [7];
      logic [31:0] ex [7];
      logic [31:0] e;
      ad = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2};
      ex = '{32'h0, 32'h0, 32'd0, 32'h0, 32'h8, 32'd1, 32'h8};
      apply_reset();
      btn[2] = 1'b1;
      wait_neg(3);
      btn[2] = 1'b0;
      wait_neg(10);
      for (int i = 0; i < 4; i++) begin
         drive_read(ad[i], ex[i]);
         e = exp_q.pop_front();
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("FAIL glitch_read%0d got valid=%b data=%h exp %h", i, rd_valid, rd_data, e);
         end
      end
      btn[3] = 1'b1;
      wait_neg(DB);
      btn[3] = 1'b0;
      wait_neg(10);
      for (int i = 4; i < 7; i++) begin
         drive_read(ad[i], ex[i]);
         e = exp_q.pop_front();
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("FAIL min_pulse_read%0d got valid=%b data=%h exp %h", i, rd_valid, rd_data, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  ad [6];
      logic [31:0] ex [6];
      logic [31:0] e;
      ad = '{2'd3, 2'd1, 2'd0, 2'd1, 2'd2, 2'd2};
      ex = '{32'd2, 32'h11, 32'h11, 32'h0, 32'h11, 32'h0};
      apply_reset();
      btn = 5'b10001;
      wait_neg(6);
      for (int i = 0; i <= 4; i++) begin
         if (i > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
               errors++;
               $display("FAIL b2b_read%0d got valid=%b data=%h exp %h", i - 1, rd_valid, rd_data, e);
            end
         end
         if (i < 4) begin
            exp_q.push_back(ex[i]);
            addr  = ad[i];
            rd_en = 1'b1;
         end else begin
            rd_en = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_valid_drop got %b exp 0", rd_valid);
      end
      btn = '0;
      wait_neg(7);
      for (int i = 4; i <= 6; i++) begin
         if (i > 4) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
               errors++;
               $display("FAIL b2b_release%0d got valid=%b data=%h exp %h", i - 1, rd_valid, rd_data, e);
            end
         end
         if (i < 6) begin
            exp_q.push_back(ex[i]);
            addr  = ad[i];
            rd_en = 1'b1;
         end else begin
            rd_en = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_wrap();
      logic [1:0]  ad [3];
      logic [31:0] ex [3];
      logic [31:0] e;
      ad = '{2'd3, 2'd3, 2'd1};
      ex = '{32'hFFFF_FFFF, 32'h0, 32'h4};
      apply_reset();
      force dut.count_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.count_q;
      drive_read(ad[0], ex[0]);
      e = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
         errors++;
         $display("FAIL wrap_preload got valid=%b data=%h exp %h", rd_valid, rd_data, e);
      end
      btn[2] = 1'b1;
      wait_neg(6);
      for (int i = 1; i < 3; i++) begin
         drive_read(ad[i], ex[i]);
         e = exp_q.pop_front();
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("FAIL wrap_read%0d got valid=%b data=%h exp %h", i, rd_valid, rd_data, e);
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [1:0]  ad [4];
      logic [31:0] e;
      ad = '{2'd0, 2'd1, 2'd2, 2'd3};
      apply_reset();
      btn[0] = 1'b1;
      wait_neg(3);
      addr  = 2'd3;
      rd_en = 1'b1;
      #2 reset = 1'b0;
      #1;
      checks++;
      if (rd_valid !== 1'b0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_reset got valid=%b irq=%b exp 0 0", rd_valid, irq);
      end
      btn   = '0;
      rd_en = 1'b0;
      wait_neg(2);
      reset = 1'b1;
      wait_neg(10);
      checks++;
      if (rd_valid !== 1'b0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL abort_after got valid=%b irq=%b exp 0 0", rd_valid, irq);
      end
      for (int i = 0; i < 4; i++) begin
         drive_read(ad[i], 32'd0);
         e = exp_q.pop_front();
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("FAIL abort_read%0d got valid=%b data=%h exp %h", i, rd_valid, rd_data, e);
         end
      end
   endtask

   // Reset while held high clears everything asynchronously, then the press re-debounces
   task automatic test_fresh_press();
      logic [31:0] e;
      apply_reset();
      btn[1] = 1'b1;
      wait_neg(7);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL fresh_pre_irq got %b exp 1", irq);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (irq !== 1'b0 || rd_data !== 32'd0) begin
         errors++;
         $display("FAIL fresh_async_clear got irq=%b data=%h exp 0 0", irq, rd_data);
      end
      @(negedge clk);
      reset = 1'b1;
      wait_neg(5);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL fresh_irq_early got %b exp 0", irq);
      end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL fresh_irq_set got %b exp 1", irq);
      end
      drive_read(2'd3, 32'd1);
      e = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
         errors++;
         $display("FAIL fresh_count got valid=%b data=%h exp %h", rd_valid, rd_data, e);
      end
      drive_read(2'd1, 32'h2);
      e = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
         errors++;
         $display("FAIL fresh_press got valid=%b data=%h exp %h", rd_valid, rd_data, e);
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_clear_race();
      test_glitch();
      test_back_to_back();
      test_wrap();
      test_reset_abort();
      test_fresh_press();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
